// File: rtl/hash_table_pkg.sv
// Shared widths, opcodes, result codes and record layouts for the chained hash table engine.
package hash_table_pkg;

  localparam int KEY_WIDTH        = 32;
  localparam int VALUE_WIDTH      = 16;
  localparam int BUCKET_WIDTH     = 8;
  localparam int TABLE_ADDR_WIDTH = 10;
  localparam string HASH_TYPE     = "dummy";

  typedef logic [KEY_WIDTH-1:0]        ht_key_t;
  typedef logic [VALUE_WIDTH-1:0]      ht_value_t;
  typedef logic [BUCKET_WIDTH-1:0]     ht_bucket_t;
  typedef logic [TABLE_ADDR_WIDTH-1:0] ht_addr_t;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_SEARCH = 2'd1,
    OP_INSERT = 2'd2,
    OP_DELETE = 2'd3
  } ht_opcode_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND                     = 3'd0,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
    INSERT_SUCCESS                   = 3'd2,
    INSERT_SUCCESS_SAME_KEY          = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
    DELETE_SUCCESS                   = 3'd5,
    DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6,
    INIT_SUCCESS                     = 3'd7
  } ht_rescode_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_HEAD_RD, ST_DATA_RD, ST_CMP, ST_WRITE, ST_RESP
  } ht_state_t;

  typedef struct packed {
    ht_opcode_t opcode;
    ht_key_t    key;
    ht_value_t  value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t cmd;
    ht_rescode_t rescode;
    ht_bucket_t  bucket;
    ht_value_t   found_value;
  } ht_result_t;

  typedef struct packed {
    logic     valid;
    ht_addr_t addr;
  } ht_head_t;

  typedef struct packed {
    ht_key_t   key;
    ht_value_t value;
    ht_addr_t  next;
    logic      next_valid;
  } ht_entry_t;

endpackage

// File: rtl/ht_empty_ptr_fifo.sv
// Free-list FIFO of data-table addresses; cleared on init, then refilled one push per cycle.
module ht_empty_ptr_fifo #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic          pop_i,
  output logic [AW-1:0] pop_addr_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;

  // NOTE: storage is deliberately not reset; only the pointers are, so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= push_addr_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_addr_o = mem[rd_ptr_q];
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/hash_table_engine.sv
// Chained hash table engine: head table + linked data table + free list, one command at a time.
// Optional occupancy output fill_cnt_o is built when HT_FILL_CNT_EN is defined.
module hash_table_engine
  import hash_table_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [1:0]                  cmd_opcode_i,
  input  logic [KEY_WIDTH-1:0]        cmd_key_i,
  input  logic [VALUE_WIDTH-1:0]      cmd_value_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [1:0]                  res_opcode_o,
  output logic [KEY_WIDTH-1:0]        res_key_o,
  output logic [VALUE_WIDTH-1:0]      res_value_o,
  output logic [2:0]                  res_rescode_o,
  output logic [BUCKET_WIDTH-1:0]     res_bucket_o,
  output logic                        init_busy_o
`ifdef HT_FILL_CNT_EN
  ,
  output logic [TABLE_ADDR_WIDTH:0]   fill_cnt_o
`endif
);

  localparam int NUM_BUCKETS = 1 << BUCKET_WIDTH;
  localparam int NUM_ENTRIES = 1 << TABLE_ADDR_WIDTH;
  localparam int INIT_CYCLES = (NUM_BUCKETS > NUM_ENTRIES) ? NUM_BUCKETS : NUM_ENTRIES;
  localparam int INIT_W      = $clog2(INIT_CYCLES) + 1;
  localparam logic [INIT_W-1:0] INIT_LAST    = INIT_W'(INIT_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_HEADS   = INIT_W'(NUM_BUCKETS);
  localparam logic [INIT_W-1:0] INIT_ENTRIES = INIT_W'(NUM_ENTRIES);
  localparam ht_addr_t HOP_LAST = '1;

  ht_state_t   state_q;
  ht_command_t cmd_q;
  ht_bucket_t  bucket_q;
  ht_head_t    head_q;
  ht_addr_t    cur_addr_q, prev_addr_q, hop_cnt_q;
  logic        prev_valid_q, found_q;
  ht_key_t     prev_key_q;
  ht_value_t   prev_value_q;
  ht_addr_t    match_next_q;
  logic        match_next_valid_q;
  logic [INIT_W-1:0] init_cnt_q;
  logic        init_cmd_q, init_busy_q, cmd_ready_q, res_valid_q;
  ht_result_t  res_q;

  ht_head_t  head_mem [NUM_BUCKETS];
  ht_entry_t data_mem [NUM_ENTRIES];
  ht_head_t  head_rd_q;
  ht_entry_t data_rd_q;

  ht_opcode_t  cmd_op_in;
  logic        cmd_fire;
  ht_bucket_t  head_raddr;
  logic        head_we, data_we;
  ht_bucket_t  head_waddr;
  ht_addr_t    data_waddr;
  ht_head_t    head_wdata;
  ht_entry_t   data_wdata;
  logic        fifo_clear, fifo_push, fifo_pop, free_empty;
  ht_addr_t    fifo_push_addr, free_addr;
  logic        miss_to_write;
  ht_rescode_t miss_code;

  assign cmd_op_in = ht_opcode_t'(cmd_opcode_i);
  assign cmd_fire  = cmd_ready_q && cmd_valid_i;
  // The head read is issued in the accept cycle so HEAD_RD already sees the bucket head.
  assign head_raddr = (state_q == ST_IDLE) ? cmd_key_i[KEY_WIDTH-1 -: BUCKET_WIDTH] : bucket_q;

  function automatic ht_result_t make_result(input ht_command_t cmd, input ht_bucket_t bucket,
                                             input ht_rescode_t code, input ht_value_t found);
    ht_result_t r;
    r.cmd         = cmd;
    r.rescode     = code;
    r.bucket      = bucket;
    r.found_value = (code == SEARCH_FOUND)     ? found :
                    (cmd.opcode == OP_INSERT) ? cmd.value : '0;
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    head_we        = 1'b0;
    head_waddr     = bucket_q;
    head_wdata     = '0;
    data_we        = 1'b0;
    data_waddr     = cur_addr_q;
    data_wdata     = '0;
    fifo_push      = 1'b0;
    fifo_push_addr = cur_addr_q;
    fifo_pop       = 1'b0;
    fifo_clear     = cmd_fire && (cmd_op_in == OP_INIT);
    miss_to_write  = (cmd_q.opcode == OP_INSERT) && !free_empty;
    case (cmd_q.opcode)
      OP_SEARCH: miss_code = SEARCH_NOT_SUCCESS_NO_ENTRY;
      OP_INSERT: miss_code = INSERT_NOT_SUCCESS_TABLE_IS_FULL;
      OP_DELETE: miss_code = DELETE_NOT_SUCCESS_NO_ENTRY;
      default:   miss_code = INIT_SUCCESS;
    endcase
    case (state_q)
      ST_INIT: begin
        head_we        = (init_cnt_q < INIT_HEADS);
        head_waddr     = init_cnt_q[BUCKET_WIDTH-1:0];
        fifo_push      = (init_cnt_q < INIT_ENTRIES);
        fifo_push_addr = init_cnt_q[TABLE_ADDR_WIDTH-1:0];
      end
      ST_WRITE: begin
        if (cmd_q.opcode == OP_INSERT) begin
          data_we = 1'b1;
          if (found_q) begin
            data_wdata = '{key: cmd_q.key, value: cmd_q.value,
                           next: match_next_q, next_valid: match_next_valid_q};
          end else begin
            // New entries are pushed at the chain head.
            fifo_pop   = 1'b1;
            data_waddr = free_addr;
            data_wdata = '{key: cmd_q.key, value: cmd_q.value,
                           next: head_q.addr, next_valid: head_q.valid};
            head_we    = 1'b1;
            head_wdata = '{valid: 1'b1, addr: free_addr};
          end
        end else if (cmd_q.opcode == OP_DELETE) begin
          fifo_push = 1'b1;
          if (prev_valid_q) begin
            data_we    = 1'b1;
            data_waddr = prev_addr_q;
            data_wdata = '{key: prev_key_q, value: prev_value_q,
                           next: match_next_q, next_valid: match_next_valid_q};
          end else begin
            head_we    = 1'b1;
            head_wdata = '{valid: match_next_valid_q, addr: match_next_q};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (head_we) head_mem[head_waddr] <= head_wdata;
    head_rd_q <= head_mem[head_raddr];
  end

  always_ff @(posedge clk_i) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    data_rd_q <= data_mem[cur_addr_q];
  end

  ht_empty_ptr_fifo #(.AW(TABLE_ADDR_WIDTH)) u_free_list (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (fifo_clear),
    .push_i      (fifo_push),
    .push_addr_i (fifo_push_addr),
    .pop_i       (fifo_pop),
    .pop_addr_o  (free_addr),
    .empty_o     (free_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      init_cmd_q   <= 1'b0;
      init_busy_q  <= 1'b1;
      cmd_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_q        <= '0;
      prev_valid_q <= 1'b0;
      found_q      <= 1'b0;
      hop_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_fire) begin
          cmd_q        <= '{opcode: cmd_op_in, key: cmd_key_i, value: cmd_value_i};
          bucket_q     <= cmd_key_i[KEY_WIDTH-1 -: BUCKET_WIDTH];
          cmd_ready_q  <= 1'b0;
          prev_valid_q <= 1'b0;
          found_q      <= 1'b0;
          hop_cnt_q    <= '0;
          if (cmd_op_in == OP_INIT) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_cmd_q  <= 1'b1;
            init_busy_q <= 1'b1;
          end else begin
            state_q <= ST_HEAD_RD;
          end
        end
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == INIT_LAST) begin
            init_busy_q <= 1'b0;
            init_cmd_q  <= 1'b0;
            if (init_cmd_q) begin
              res_q       <= make_result(cmd_q, bucket_q, INIT_SUCCESS, '0);
              res_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_HEAD_RD: begin
          head_q     <= head_rd_q;
          cur_addr_q <= head_rd_q.addr;
          if (head_rd_q.valid) begin
            state_q <= ST_DATA_RD;
          end else if (miss_to_write) begin
            state_q <= ST_WRITE;
          end else begin
            res_q       <= make_result(cmd_q, bucket_q, miss_code, '0);
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_DATA_RD: state_q <= ST_CMP;
        ST_CMP: begin
          if (data_rd_q.key == cmd_q.key) begin
            found_q            <= 1'b1;
            match_next_q       <= data_rd_q.next;
            match_next_valid_q <= data_rd_q.next_valid;
            if (cmd_q.opcode == OP_SEARCH) begin
              res_q       <= make_result(cmd_q, bucket_q, SEARCH_FOUND, data_rd_q.value);
              res_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              state_q <= ST_WRITE;
            end
          end else if (data_rd_q.next_valid && hop_cnt_q != HOP_LAST) begin
            // A chain can never legally exceed the table size; longer walks mean corruption.
            prev_addr_q  <= cur_addr_q;
            prev_valid_q <= 1'b1;
            prev_key_q   <= data_rd_q.key;
            prev_value_q <= data_rd_q.value;
            cur_addr_q   <= data_rd_q.next;
            hop_cnt_q    <= hop_cnt_q + 1'b1;
            state_q      <= ST_DATA_RD;
          end else if (miss_to_write) begin
            state_q <= ST_WRITE;
          end else begin
            res_q       <= make_result(cmd_q, bucket_q, miss_code, '0);
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          res_q <= make_result(cmd_q, bucket_q,
                               (cmd_q.opcode == OP_DELETE) ? DELETE_SUCCESS :
                               found_q ? INSERT_SUCCESS_SAME_KEY : INSERT_SUCCESS, '0);
          res_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: if (res_ready_i) begin
          res_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

`ifdef HT_FILL_CNT_EN
  logic [TABLE_ADDR_WIDTH:0] fill_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i || fifo_clear) begin
      fill_cnt_q <= '0;
    end else if (state_q == ST_WRITE) begin
      if (cmd_q.opcode == OP_INSERT && !found_q) fill_cnt_q <= fill_cnt_q + 1'b1;
      else if (cmd_q.opcode == OP_DELETE)       fill_cnt_q <= fill_cnt_q - 1'b1;
    end
  end

  assign fill_cnt_o = fill_cnt_q;
`endif

  assign cmd_ready_o   = cmd_ready_q;
  assign res_valid_o   = res_valid_q;
  assign res_opcode_o  = res_q.cmd.opcode;
  assign res_key_o     = res_q.cmd.key;
  assign res_value_o   = res_q.found_value;
  assign res_rescode_o = res_q.rescode;
  assign res_bucket_o  = res_q.bucket;
  assign init_busy_o   = init_busy_q;

endmodule

// File: tb/tb_hash_table_engine.sv
// Self-checking bench for hash_table_engine against an associative-array model of the table.
module tb_hash_table_engine;
  import hash_table_pkg::*;

  localparam int N     = 1 << TABLE_ADDR_WIDTH;
  localparam int LIMIT = 4000;

  logic                    clk = 1'b0;
  logic                    rst_i;
  logic                    cmd_valid_i, cmd_ready_o;
  logic [1:0]              cmd_opcode_i;
  logic [KEY_WIDTH-1:0]    cmd_key_i;
  logic [VALUE_WIDTH-1:0]  cmd_value_i;
  logic                    res_valid_o, res_ready_i;
  logic [1:0]              res_opcode_o;
  logic [KEY_WIDTH-1:0]    res_key_o;
  logic [VALUE_WIDTH-1:0]  res_value_o;
  logic [2:0]              res_rescode_o;
  logic [BUCKET_WIDTH-1:0] res_bucket_o;
  logic                    init_busy_o;
`ifdef HT_FILL_CNT_EN
  logic [TABLE_ADDR_WIDTH:0] fill_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [VALUE_WIDTH-1:0] model [logic [KEY_WIDTH-1:0]];
  bit used [logic [KEY_WIDTH-1:0]];

  always #5 clk = ~clk;

  hash_table_engine dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_opcode_i  (cmd_opcode_i),
    .cmd_key_i     (cmd_key_i),
    .cmd_value_i   (cmd_value_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_opcode_o  (res_opcode_o),
    .res_key_o     (res_key_o),
    .res_value_o   (res_value_o),
    .res_rescode_o (res_rescode_o),
    .res_bucket_o  (res_bucket_o),
    .init_busy_o   (init_busy_o)
`ifdef HT_FILL_CNT_EN
    ,
    .fill_cnt_o    (fill_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic abort(input string tag);
    miscompares++;
    $display("FAIL %s: no DUT response within %0d cycles", tag, LIMIT);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "bench stopped early");
  endtask

  task automatic wait_init_done(output int cycles);
    cycles = 0;
    while (init_busy_o) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles > LIMIT) abort("init_busy");
    end
  endtask

  task automatic do_cmd(input ht_opcode_t op, input logic [KEY_WIDTH-1:0] key,
                        input logic [VALUE_WIDTH-1:0] val, input bit bp);
    ht_rescode_t            exp_code;
    logic [VALUE_WIDTH-1:0] exp_val;
    logic [60:0]            snap;
    bit                     seen;
    int                     n;
    exp_val = '0;
    case (op)
      OP_INIT: begin
        model.delete();
        exp_code = INIT_SUCCESS;
      end
      OP_SEARCH: begin
        if (model.exists(key)) begin
          exp_code = SEARCH_FOUND;
          exp_val  = model[key];
        end else exp_code = SEARCH_NOT_SUCCESS_NO_ENTRY;
      end
      OP_INSERT: begin
        exp_val = val;
        if (model.exists(key)) begin
          exp_code   = INSERT_SUCCESS_SAME_KEY;
          model[key] = val;
        end else if (model.num() >= N) begin
          exp_code = INSERT_NOT_SUCCESS_TABLE_IS_FULL;
        end else begin
          exp_code   = INSERT_SUCCESS;
          model[key] = val;
        end
      end
      default: begin
        if (model.exists(key)) begin
          exp_code = DELETE_SUCCESS;
          model.delete(key);
        end else exp_code = DELETE_NOT_SUCCESS_NO_ENTRY;
      end
    endcase

    n = 0;
    @(negedge clk);
    while (!cmd_ready_o) begin
      if (++n > LIMIT) abort("cmd_ready");
      @(negedge clk);
    end
    cmd_valid_i  = 1'b1;
    cmd_opcode_i = op;
    cmd_key_i    = key;
    cmd_value_i  = val;
    @(negedge clk);
    cmd_valid_i  = 1'b0;
    cmd_opcode_i = 2'($urandom);
    cmd_key_i    = $urandom;
    cmd_value_i  = 16'($urandom);

    seen = 1'b0;
    snap = '0;
    n = 0;
    forever begin
      res_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_valid_o) begin
        if (!seen) begin
          snap = {res_opcode_o, res_key_o, res_value_o, res_rescode_o, res_bucket_o};
          seen = 1'b1;
        end else begin
          check("res_stable", {res_opcode_o, res_key_o, res_value_o, res_rescode_o, res_bucket_o}, snap);
        end
        if (res_ready_i) break;
      end
      if (++n > LIMIT) abort("res_valid");
      @(negedge clk);
    end
    @(negedge clk);
    res_ready_i = 1'b0;
    check("res_valid_drop", res_valid_o, 1'b0);
    check("res_opcode",  snap[60:59], op);
    check("res_key",     snap[58:27], key);
    check("res_value",   snap[26:11], exp_val);
    check("res_rescode", snap[10:8],  exp_code);
    check("res_bucket",  snap[7:0],   key[KEY_WIDTH-1 -: BUCKET_WIDTH]);
`ifdef HT_FILL_CNT_EN
    check("fill_cnt", fill_cnt_o, model.num());
`endif
  endtask

  initial begin
    int cycles;
    logic [KEY_WIDTH-1:0] key, first_key;
    ht_opcode_t op;

    rst_i        = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_opcode_i = '0;
    cmd_key_i    = '0;
    cmd_value_i  = '0;
    res_ready_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready_o, 1'b0);
    check("rst_res_valid", res_valid_o, 1'b0);
    check("rst_res_fields", {res_opcode_o, res_key_o, res_value_o, res_rescode_o, res_bucket_o}, '0);
    check("rst_init_busy", init_busy_o, 1'b1);
    rst_i = 1'b1;
    wait_init_done(cycles);
    check("init_cycles", cycles, N);
    check("ready_after_init", cmd_ready_o, 1'b1);

    // Basic directed sequence.
    do_cmd(OP_INIT,   32'h0000_0000, 16'h0,    1'b0);
    do_cmd(OP_SEARCH, 32'h0400_0000, 16'h0,    1'b0);
    do_cmd(OP_INSERT, 32'h0100_0000, 16'h1234, 1'b0);
    do_cmd(OP_INSERT, 32'h0100_1000, 16'h1235, 1'b0);
    do_cmd(OP_SEARCH, 32'h0100_0000, 16'h0,    1'b0);
    do_cmd(OP_SEARCH, 32'h0100_1000, 16'h0,    1'b0);
    do_cmd(OP_INSERT, 32'h0100_0000, 16'hBEEF, 1'b0);
    do_cmd(OP_SEARCH, 32'h0100_0000, 16'h0,    1'b0);

    // Three-entry chain in bucket 5: chain order is 3 -> 2 -> 1.
    for (int i = 1; i <= 3; i++) do_cmd(OP_INSERT, 32'h0500_0000 + i, 16'(16'hA000 + i), 1'b0);
    do_cmd(OP_DELETE, 32'h0500_0002, 16'h0, 1'b0);
    for (int i = 1; i <= 3; i++) do_cmd(OP_SEARCH, 32'h0500_0000 + i, 16'h0, 1'b0);
    do_cmd(OP_DELETE, 32'h0500_0003, 16'h0, 1'b0);
    do_cmd(OP_SEARCH, 32'h0500_0001, 16'h0, 1'b0);
    do_cmd(OP_INSERT, 32'h0500_0002, 16'hB002, 1'b0);
    do_cmd(OP_INSERT, 32'h0500_0003, 16'hB003, 1'b0);
    do_cmd(OP_DELETE, 32'h0500_0001, 16'h0, 1'b0);
    for (int i = 1; i <= 3; i++) do_cmd(OP_SEARCH, 32'h0500_0000 + i, 16'h0, 1'b0);
    do_cmd(OP_DELETE, 32'h0411_1111, 16'h0, 1'b0);

    // Reset while a command is in flight: result dropped, table reinitialised.
    @(negedge clk);
    while (!cmd_ready_o) @(negedge clk);
    cmd_valid_i  = 1'b1;
    cmd_opcode_i = OP_INSERT;
    cmd_key_i    = 32'h0700_0007;
    cmd_value_i  = 16'h7777;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    rst_i       = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    check("midrst_res_valid", res_valid_o, 1'b0);
    check("midrst_cmd_ready", cmd_ready_o, 1'b0);
    check("midrst_init_busy", init_busy_o, 1'b1);
    wait_init_done(cycles);
    model.delete();
    do_cmd(OP_SEARCH, 32'h0700_0007, 16'h0, 1'b0);
    do_cmd(OP_SEARCH, 32'h0100_0000, 16'h0, 1'b0);

    // Fill the table past capacity with distinct keys.
    do_cmd(OP_INIT, 32'h0, 16'h0, 1'b0);
    used.delete();
    first_key = '0;
    for (int i = 0; i < N + 10; i++) begin
      do key = $urandom; while (used.exists(key));
      used[key] = 1'b1;
      if (i == 0) first_key = key;
      do_cmd(OP_INSERT, key, 16'($urandom), 1'b0);
    end
    do_cmd(OP_DELETE, first_key, 16'h0, 1'b0);
    do key = $urandom; while (used.exists(key));
    do_cmd(OP_INSERT, key, 16'h5A5A, 1'b0);
    do_cmd(OP_SEARCH, key, 16'h0, 1'b0);

    // Random mix on a small colliding key pool with result back-pressure.
    do_cmd(OP_INIT, 32'h0, 16'h0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      op  = ht_opcode_t'($urandom_range(1, 3));
      if ($urandom_range(0, 79) == 0) op = OP_INIT;
      key = {8'($urandom_range(0, 3)), 21'h0, 3'($urandom_range(0, 7))};
      do_cmd(op, key, 16'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
